// File: rtl/mult_seq_controller_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer: function codes,
// state encoding and the Moore output decode.
package mult_seq_controller_pkg;

    typedef enum logic [2:0] {
        FS_NOP  = 3'b000,
        FS_LOAD = 3'b001,
        FS_CLR  = 3'b010,
        FS_ADD  = 3'b011,
        FS_SUB  = 3'b100,
        FS_SHR  = 3'b101
    } fs_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLR   = 3'd2,
        S_TEST  = 3'd3,
        S_ADDS  = 3'd4,
        S_SUBS  = 3'd5,
        S_SHIFT = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    typedef struct packed {
        logic wen;
        logic sel;
        fs_e  fs;
        logic busy;
        logic done;
    } ctl_out_t;

    // Datapath controls implied by a state; IDLE decodes to all zeros.
    function automatic ctl_out_t decode(input state_e s);
        ctl_out_t o;
        o      = '0;
        o.fs   = FS_NOP;
        o.busy = (s != S_IDLE);
        case (s)
            S_LOAD:  begin o.wen = 1'b1; o.sel = 1'b1; o.fs = FS_LOAD; end
            S_CLR:   begin o.wen = 1'b1; o.fs = FS_CLR; end
            S_ADDS:  begin o.wen = 1'b1; o.fs = FS_ADD; end
            S_SUBS:  begin o.wen = 1'b1; o.fs = FS_SUB; end
            S_SHIFT: begin o.wen = 1'b1; o.fs = FS_SHR; end
            S_DONE:  o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mult_seq_controller_iter_counter.sv
// Shift counter for the multiplier sequencer; saturates at WIDTH-1 and flags the last iteration.
module mult_seq_controller_iter_counter #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last_c
);

    assign last_c = (count == CNT_W'(WIDTH - 1));

    // Holding at the last value keeps count==WIDTH-1 visible through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !last_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_seq_controller.sv
// Moore sequencer for a WIDTH-bit shift-and-add multiplier with start/busy/done
// handshake, signed (MSB-subtract) mode and synchronous abort.
module mult_seq_controller
    import mult_seq_controller_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             abort,
    input  logic             X0,
    output logic             WEN,
    output logic             SEL,
    output logic [2:0]       FS,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    state_e   state_q, state_d;
    ctl_out_t out_q;
    logic     signed_q;
    logic     cnt_clr, cnt_inc, last_c;
    logic     accept_c;

    assign accept_c = (state_q == S_IDLE) && start && !abort;

    mult_seq_controller_iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
        .clk    (CLK),
        .rst_n  (resetn),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (count),
        .last_c (last_c)
    );

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_d = S_LOAD;
                        cnt_clr = 1'b1;
                    end
                end
                S_LOAD:  state_d = S_CLR;
                S_CLR:   state_d = S_TEST;
                S_TEST: begin
                    if (X0) state_d = (last_c && signed_q) ? S_SUBS : S_ADDS;
                    else    state_d = S_SHIFT;
                end
                S_ADDS:  state_d = S_SHIFT;
                S_SUBS:  state_d = S_SHIFT;
                S_SHIFT: begin
                    cnt_inc = 1'b1;
                    state_d = last_c ? S_DONE : S_TEST;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are flopped from the decode of the next state, so they track the state register exactly.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            out_q    <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= decode(state_d);
            if (accept_c) begin
                signed_q <= signed_mode;
            end
        end
    end

    assign WEN  = out_q.wen;
    assign SEL  = out_q.sel;
    assign FS   = out_q.fs;
    assign busy = out_q.busy;
    assign done = out_q.done;

endmodule
